// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline register banks.
//   RESET_PC_DEFAULT : fetch address loaded on reset
//   NOP_INSTR        : all-zero instruction word inserted on an IF/ID flush
//   ALU_CTRL_W       : width of the ALUControl field
//   idex_ctrl_t      : control group carried from ID into EX (and onward into
//                      the M/W banks, which keep the subset they need)
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          ALU_CTRL_W       = 3;

    // An all-zero value of this struct is a bubble: no register write and
    // no memory write, so it has no architectural effect.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_dst;
        logic [ALU_CTRL_W-1:0] alu_control;
    } idex_ctrl_t;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. Debug use only.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   inc   : count this edge
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: the default assignment first means every path writes cnt_d, so no
    // latch is inferred in this combinational block.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_front_regs.sv
// -----------------------------------------------------------------------------
// pipe_front_regs
// Front-half pipeline registers of the 5-stage MIPS core: the PC register (F),
// the IF/ID register (D) and the ID/EX register (E). Applies the hazard unit's
// hold (StallF/StallD), bubble (FlushE) and branch flush (PCSrcD) each cycle,
// and keeps saturating debug counters of stall and bubble cycles.
//
// Ports
//   clk, rst_n                     : clock, asynchronous active-low reset
//   StallF, StallD, FlushE         : hazard-unit controls
//   PCSrcD, PCBranchD              : branch taken in D and its target
//   PCNextF, PCF, PCPlus4F         : next PC (comb), fetch PC, PCF+4 (comb)
//   InstrF                         : instruction read from I-mem at PCF
//   InstrD, PCPlus4D, ValidD       : IF/ID register contents
//   *D decoded controls/operands   : ID-stage values entering ID/EX
//   *E registered controls/operands: ID/EX register contents, ValidE
//   StallCnt, BubbleCnt            : saturating debug counters
// -----------------------------------------------------------------------------
module pipe_front_regs
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushE,
    input  logic                  PCSrcD,
    input  logic [31:0]           PCBranchD,
    output logic [31:0]           PCNextF,
    output logic [31:0]           PCF,
    input  logic [31:0]           InstrF,
    output logic [31:0]           PCPlus4F,
    output logic [31:0]           InstrD,
    output logic [31:0]           PCPlus4D,
    output logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic                  MemtoRegD,
    input  logic                  MemWriteD,
    input  logic                  ALUSrcD,
    input  logic                  RegDstD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    input  logic [31:0]           RD1D,
    input  logic [31:0]           RD2D,
    input  logic [31:0]           SignImmD,
    input  logic [4:0]            RsD,
    input  logic [4:0]            RtD,
    input  logic [4:0]            RdD,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [31:0]           RD1E,
    output logic [31:0]           RD2E,
    output logic [31:0]           SignImmE,
    output logic [4:0]            RsE,
    output logic [4:0]            RtE,
    output logic [4:0]            RdE,
    output logic                  ValidE,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      BubbleCnt
);

    // ---------------- F stage ----------------
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    // ---------------- IF/ID ----------------
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pcp4_q,  ifid_pcp4_d;
    logic        ifid_valid_q, ifid_valid_d;

    // ---------------- ID/EX ----------------
    idex_ctrl_t  idex_ctrl_q,  idex_ctrl_d;
    idex_ctrl_t  ctrl_in;
    logic [31:0] idex_rd1_q,   idex_rd1_d;
    logic [31:0] idex_rd2_q,   idex_rd2_d;
    logic [31:0] idex_imm_q,   idex_imm_d;
    logic [4:0]  idex_rs_q,    idex_rs_d;
    logic [4:0]  idex_rt_q,    idex_rt_d;
    logic [4:0]  idex_rd_q,    idex_rd_d;
    logic        idex_valid_q, idex_valid_d;

    // PC arithmetic wraps modulo 2^32 by width truncation.
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_next  = PCSrcD ? PCBranchD : pc_plus4;

    assign ctrl_in = '{
        reg_write:   RegWriteD,
        mem_to_reg:  MemtoRegD,
        mem_write:   MemWriteD,
        alu_src:     ALUSrcD,
        reg_dst:     RegDstD,
        alu_control: ALUControlD
    };

    always_comb begin
        pc_d = pc_q;
        if (!StallF) begin
            pc_d = pc_next;
        end
    end

    // StallD takes priority over PCSrcD: during a branch stall the branch
    // operands are still being forwarded, so PCSrcD is not yet trustworthy.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pcp4_d  = ifid_pcp4_q;
        ifid_valid_d = ifid_valid_q;
        if (!StallD) begin
            if (PCSrcD) begin
                ifid_instr_d = NOP_INSTR;
                ifid_pcp4_d  = '0;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = InstrF;
                ifid_pcp4_d  = pc_plus4;
                ifid_valid_d = 1'b1;
            end
        end
    end

    // ID/EX has no stall: it either takes a bubble or advances. FlushE wins
    // even under StallD, which is how a load-use bubble is inserted.
    always_comb begin
        idex_ctrl_d  = ctrl_in;
        idex_rd1_d   = RD1D;
        idex_rd2_d   = RD2D;
        idex_imm_d   = SignImmD;
        idex_rs_d    = RsD;
        idex_rt_d    = RtD;
        idex_rd_d    = RdD;
        idex_valid_d = ifid_valid_q;
        if (FlushE) begin
            idex_ctrl_d  = '0;
            idex_rd1_d   = '0;
            idex_rd2_d   = '0;
            idex_imm_d   = '0;
            idex_rs_d    = '0;
            idex_rt_d    = '0;
            idex_rd_d    = '0;
            idex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pcp4_q  <= '0;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
            idex_rd1_q   <= '0;
            idex_rd2_q   <= '0;
            idex_imm_q   <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
            idex_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pcp4_q  <= ifid_pcp4_d;
            ifid_valid_q <= ifid_valid_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rd1_q   <= idex_rd1_d;
            idex_rd2_q   <= idex_rd2_d;
            idex_imm_q   <= idex_imm_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_rd_q    <= idex_rd_d;
            idex_valid_q <= idex_valid_d;
        end
    end

    // A branch flush while D is stalled does not happen (StallD wins), so it
    // is not counted; a flush and a branch on the same edge count once.
    logic bubble_inc;
    assign bubble_inc = FlushE | (PCSrcD & ~StallD);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF),
        .q     (StallCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .q     (BubbleCnt)
    );

    assign PCNextF     = pc_next;
    assign PCF         = pc_q;
    assign PCPlus4F    = pc_plus4;
    assign InstrD      = ifid_instr_q;
    assign PCPlus4D    = ifid_pcp4_q;
    assign ValidD      = ifid_valid_q;
    assign RegWriteE   = idex_ctrl_q.reg_write;
    assign MemtoRegE   = idex_ctrl_q.mem_to_reg;
    assign MemWriteE   = idex_ctrl_q.mem_write;
    assign ALUSrcE     = idex_ctrl_q.alu_src;
    assign RegDstE     = idex_ctrl_q.reg_dst;
    assign ALUControlE = idex_ctrl_q.alu_control;
    assign RD1E        = idex_rd1_q;
    assign RD2E        = idex_rd2_q;
    assign SignImmE    = idex_imm_q;
    assign RsE         = idex_rs_q;
    assign RtE         = idex_rt_q;
    assign RdE         = idex_rd_q;
    assign ValidE      = idex_valid_q;

endmodule : pipe_front_regs

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
Pipeline-register bank for the front half of the 5-stage MIPS pipeline: PC register (F), IF/ID register (D) and ID/EX register (E). It is the consumer of the hazard controller's StallF/StallD/FlushE outputs and of the branch-resolution signal PCSrcD. It applies hold, flush and bubble insertion each cycle. It also keeps saturating stall/bubble counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the debug stall and bubble counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hold PC register
StallD  in  1  hold IF/ID register
FlushE  in  1  clear ID/EX register (insert bubble)
PCSrcD  in  1  branch taken in D; flush IF/ID
PCBranchD  in  32  branch target
PCNextF  out  32  selected next PC (combinational)
PCF  out  32  current fetch PC
InstrF  in  32  instruction from I-mem
PCPlus4F  out  32  PCF+4 (combinational)
InstrD  out  32  registered instruction
PCPlus4D  out  32  registered PC+4
ValidD  out  1  IF/ID holds a real instruction
RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decoded controls
ALUControlD  in  3  ALU op
RD1D, RD2D, SignImmD  in  32 each  operands
RsD, RtD, RdD  in  5 each  register fields
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered controls
ALUControlE  out  3  registered ALU op
RD1E, RD2E, SignImmE  out  32 each  registered operands
RsE, RtE, RdE  out  5 each  registered fields
ValidE  out  1  ID/EX holds a real instruction
StallCnt  out  CNT_W  cycles with StallF=1
BubbleCnt  out  CNT_W  cycles with FlushE=1 or PCSrcD flush

Behaviour:
- Reset: rst_n low asynchronously sets PCF=RESET_PC. Every D and E register output, ValidD, ValidE, StallCnt and BubbleCnt are set to 0. Outputs are valid from the first rising edge after release.
- PCPlus4F = PCF+4, modulo 2^32 (wraps 32'hFFFF_FFFC to 0). PCNextF = PCSrcD ? PCBranchD : PCPlus4F.
- F stage, per edge: if StallF, PCF holds; else PCF <= PCNextF.
- D stage, per edge, in priority order:
  - StallD: hold InstrD, PCPlus4D, ValidD. StallD beats PCSrcD because the branch is not yet resolved under a branch stall.
  - Else if PCSrcD: InstrD <= 0 (NOP), PCPlus4D <= 0, ValidD <= 0.
  - Else: InstrD <= InstrF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- E stage, per edge:
  - FlushE: all E outputs including ValidE become 0. The all-zero word is a bubble: RegWriteE=0 and MemWriteE=0, so no architectural effect.
  - Else: all E outputs capture their D inputs. ValidE <= ValidD.
  - There is no E stall. FlushE applies even when StallD=1 (load-use case).
- Latency: an instruction fetched at edge n appears on InstrD after edge n+1 and on the E outputs after edge n+2, absent stalls.
- Load-use sequence: StallF=StallD=FlushE=1 for one cycle. PC and IF/ID freeze, one bubble enters E, and the next cycle proceeds normally.
- Counters:
  - StallCnt increments on every edge with StallF=1 and saturates at all-ones.
  - BubbleCnt increments by 1 on an edge where FlushE=1, or where PCSrcD=1 with StallD=0. It increments only once if both occur on the same edge, and saturates.
  - Neither counter wraps.
- Reset mid-stall: asynchronous clear wins immediately. There is no remembered stall state; all state here is register state.

Decomposition:
- Shared package pipe_pkg:
  - RESET_PC default.
  - NOP encoding 32'h0000_0000.
  - ALUControl width constant (3).
  - Struct/bundle typedef for the ID/EX control group (RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ALUControl), so that E/M/W stage register banks reuse it.
- One natural sub-module: sat_counter (width CNT_W, inc, rst_n, q), instantiated twice for StallCnt and BubbleCnt.

Test Plan:
- Reset then free-run with InstrF=PCF-derived pattern -> PCF goes 0,4,8,12. InstrD lags one cycle and ValidD=1 from the second edge; E outputs lag two cycles; counters stay 0.
- StallF=StallD=FlushE=1 for one cycle at PCF=8 -> PCF held at 8 and InstrD held. All E outputs go 0 with ValidE=0, then resume. StallCnt=1, BubbleCnt=1.
- PCSrcD=1, PCBranchD=32'h40, StallD=0 -> PCNextF=32'h40. PCF=32'h40 next edge, InstrD=0 with ValidD=0, BubbleCnt increments by 1.
- PCSrcD=1 with StallD=1 and StallF=1 -> PCF, InstrD and ValidD all held. The E outputs are zeroed only if FlushE=1.
- PCF reaches 32'hFFFF_FFFC unstalled -> PCPlus4F=0 and PCF=0 next edge.
- Hold StallF=1 for 2^CNT_W+5 cycles, then assert rst_n low mid-cycle -> StallCnt saturates at all-ones. All outputs clear immediately without waiting for a clock edge, and PCF=RESET_PC.
